// File: rtl/keypad_priority_encoder.sv
// Eight active-low key lines -> synchronised, debounced press events ->
// 74x148-style priority encode -> small code FIFO with valid/ready handshake.
module keypad_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic db,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          s1_q, s2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count resets whenever the synchronised level agrees with the debounced one.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) db_d = s2_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      db_q  <= 1'b1;
      cnt_q <= '0;
    end else begin
      s1_q  <= key_n;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db    = db_q;
  assign press = db_q & ~db_d;
endmodule

module keypad_priority_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    enable,
  input  logic [7:0]                    keys_n,
  output logic [2:0]                    code,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic                          gs_n,
  output logic                          eo_n,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  logic [7:0] db, press_ev;

  for (genvar i = 0; i < 8; i++) begin : g_lane
    keypad_debounce_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .key_n (keys_n[i]),
      .db    (db[i]),
      .press (press_ev[i])
    );
  end

  logic                       en;
  logic [7:0]                 pending_q, pending_d;
  logic [FIFO_DEPTH-1:0][2:0] mem_q, mem_d;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]            count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic                       gs_n_q, gs_n_d, eo_n_q, eo_n_d;
  logic                       full, pop, push;
  logic [2:0]                 push_idx;
  logic [7:0]                 push_mask;

  assign en         = (enable == 3'd4);
  assign code_valid = (count_q != '0);
  assign full       = (count_q == CNTW'(FIFO_DEPTH));
  assign pop        = code_valid & code_ready;

  always_comb begin
    push_idx = '0;
    for (int i = 0; i < 8; i++)
      if (pending_q[i]) push_idx = 3'(i);
    push      = (pending_q != '0) && (!full || pop);
    push_mask = '0;
    push_mask[push_idx] = push;

    // A press on a key that is still pending is lost and flagged.
    pending_d  = en ? ((pending_q & ~push_mask) | (press_ev & ~pending_q)) : '0;
    overflow_d = overflow_q | (en && ((press_ev & pending_q) != '0));

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_idx;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CNTW'(push) - CNTW'(pop);

    gs_n_d = ~(en && (db != 8'hff));
    eo_n_d = ~(en && (db == 8'hff));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      gs_n_q     <= 1'b1;
      eo_n_q     <= 1'b1;
    end else begin
      pending_q  <= pending_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      gs_n_q     <= gs_n_d;
      eo_n_q     <= eo_n_d;
    end
  end

  assign code       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign gs_n       = gs_n_q;
  assign eo_n       = eo_n_q;
endmodule

// File: tb/tb_keypad_priority_encoder.sv
// Directed bench for keypad_priority_encoder; delivered codes are checked
// against a queue of expected codes filled as keys are pressed.
module tb_keypad_priority_encoder;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] enable;
  logic [7:0] keys_n;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       gs_n, eo_n;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_chk  = 0;
  int n_fail = 0;
  logic [2:0] expq[$];

  keypad_priority_encoder #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .keys_n     (keys_n),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .gs_n       (gs_n),
    .eo_n       (eo_n),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press key k until it has been queued, then release and let it settle.
  task automatic press_key(input int k, input bit expect_code);
    keys_n[k] = 1'b0;
    if (expect_code) expq.push_back(3'(k));
    tick(7);
    keys_n[k] = 1'b1;
    tick(7);
  endtask

  // Consumer side: a pop happens at the next edge, so compare now.
  always @(negedge clk) begin
    if (!rst && code_valid && code_ready) begin
      if (expq.size() == 0) chk("unexpected_code", {29'd0, code}, 32'hdead);
      else chk("code_order", {29'd0, code}, {29'd0, expq.pop_front()});
    end
  end

  initial begin
    rst = 1'b1; enable = 3'd4; keys_n = 8'hff; code_ready = 1'b0;
    tick(2);
    chk("rst_valid", code_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_code", code, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_gs", gs_n, 1);
    chk("rst_eo", eo_n, 1);
    rst = 1'b0;
    tick(2);
    chk("idle_eo", eo_n, 0);

    // Single press of key 5: valid after the 7th edge, not the 6th
    keys_n = 8'hdf;
    expq.push_back(3'd5);
    tick(6);
    chk("single_not_yet", code_valid, 0);
    tick(1);
    chk("single_valid", code_valid, 1);
    chk("single_code", code, 5);
    chk("single_count", fifo_count, 1);
    chk("single_gs", gs_n, 0);
    chk("single_eo", eo_n, 1);
    code_ready = 1'b1;
    tick(1);
    code_ready = 1'b0;
    chk("single_pop_count", fifo_count, 0);
    chk("single_pop_valid", code_valid, 0);
    keys_n = 8'hff;
    tick(8);
    chk("single_release_gs", gs_n, 1);
    chk("single_release_eo", eo_n, 0);

    // Bounce: key 3 low for only 3 sampled cycles
    keys_n[3] = 1'b0;
    tick(3);
    keys_n[3] = 1'b1;
    tick(10);
    chk("bounce_count", fifo_count, 0);
    chk("bounce_gs", gs_n, 1);
    chk("bounce_valid", code_valid, 0);

    // Simultaneous keys 6 and 2: 6 queued first, 2 on the next cycle
    keys_n = 8'hbb;
    expq.push_back(3'd6);
    expq.push_back(3'd2);
    tick(7);
    chk("simul_count1", fifo_count, 1);
    chk("simul_head", code, 6);
    tick(1);
    chk("simul_count2", fifo_count, 2);
    code_ready = 1'b1;
    tick(3);
    code_ready = 1'b0;
    chk("simul_drained", fifo_count, 0);
    keys_n = 8'hff;
    tick(8);

    // Disabled: press ignored, status both high
    enable = 3'd0;
    tick(1);
    keys_n[1] = 1'b0;
    tick(10);
    chk("dis_count", fifo_count, 0);
    chk("dis_gs", gs_n, 1);
    chk("dis_eo", eo_n, 1);
    keys_n[1] = 1'b1;
    tick(8);
    enable = 3'd4;
    tick(1);
    chk("reen_eo", eo_n, 0);
    chk("reen_gs", gs_n, 1);
    chk("reen_count", fifo_count, 0);

    // Backpressure: 0..3 fill the FIFO, 4 waits in pending, re-press of 4 is lost
    for (int k = 0; k < 5; k++) press_key(k, 1'b1);
    chk("bp_full", fifo_count, 4);
    chk("bp_no_ovf", overflow, 0);
    press_key(4, 1'b0);
    chk("bp_ovf", overflow, 1);
    chk("bp_still_full", fifo_count, 4);
    code_ready = 1'b1;
    tick(10);
    code_ready = 1'b0;
    chk("bp_drained", fifo_count, 0);
    chk("bp_all_seen", expq.size(), 0);
    chk("bp_ovf_sticky", overflow, 1);

    // Reset while 3 codes are queued and key 5 is mid-debounce
    for (int k = 0; k < 3; k++) press_key(k, 1'b1);
    chk("mid_count", fifo_count, 3);
    keys_n[5] = 1'b0;
    tick(3);
    rst = 1'b1;
    keys_n = 8'hff;
    #1;
    chk("mid_rst_valid", code_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_gs", gs_n, 1);
    chk("mid_rst_eo", eo_n, 1);
    expq.delete();
    tick(1);
    rst = 1'b0;
    tick(12);
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_valid", code_valid, 0);
    chk("post_rst_gs", gs_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
